// File: rtl/rf_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: default geometry
// and the controller state encoding.
package rf_dump_reader_pkg;

  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned DW_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } rf_dump_state_t;

  // First index emitted by a dump; register 0 is optionally skipped
  // because it is hard-wired to zero on most cores.
  function automatic int unsigned first_index(input bit skip_zero);
    return skip_zero ? 1 : 0;
  endfunction

endpackage

// File: rtl/rf_dump_reader_if.sv
// Valid/ready output stream carrying one captured register per beat.
interface rf_dump_reader_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic [AW-1:0] idx;
  logic          last;

  modport master (output valid, data, idx, last, input  ready);
  modport slave  (input  valid, data, idx, last, output ready);
endinterface

// File: rtl/rf_dump_reader.sv
// Walks the register file through one asynchronous read port and streams
// each register out over a valid/ready interface, one beat per two cycles.
// The read address comes straight from a flop so the register file sees a
// glitch-free address for the whole READ cycle.
module rf_dump_reader
  import rf_dump_reader_pkg::*;
#(
  parameter int NREG      = NREG_DEF,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [AW-1:0]     ra_o,
  input  logic [DW-1:0]     rd_i,
  rf_dump_reader_if.master  out,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [AW-1:0] FIRST_IDX = AW'(first_index(SKIP_ZERO));
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREG - 1);

  rf_dump_state_t state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [DW-1:0]  data_q, data_d;
  logic [AW-1:0]  oidx_q, oidx_d;
  logic           last_q, last_d;
  logic           valid_q, valid_d;

  // State and datapath registers; reset discards any dump in progress.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      oidx_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      oidx_q  <= oidx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and datapath update; abort overrides every transition.
  // NOTE: every signal gets a hold-value default first so no path through
  // the case leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    oidx_d  = oidx_q;
    last_d  = last_q;
    valid_d = valid_q;

    if (abort_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            idx_d   = FIRST_IDX;
            state_d = READ;
          end
        end
        READ: begin
          data_d  = rd_i;
          oidx_d  = idx_q;
          last_d  = (idx_q == LAST_IDX);
          valid_d = 1'b1;
          state_d = SEND;
        end
        SEND: begin
          if (valid_q && out.ready) begin
            valid_d = 1'b0;
            if (last_q) begin
              state_d = DONE;
            end else begin
              // The last beat never increments, so NREG == 2**AW
              // cannot overflow the index.
              idx_d   = idx_q + AW'(1);
              state_d = READ;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign ra_o      = idx_q;
  assign out.valid = valid_q;
  assign out.data  = data_q;
  assign out.idx   = oidx_q;
  assign out.last  = last_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader: a per-cycle vector table for the
// handshake/abort corner cases, then multi-cycle dump sequences.
module tb_rf_dump_reader;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_a = 1'b0, start_b = 1'b0;
  logic          abort = 1'b0, ready = 1'b0;
  logic [AW-1:0] ra_a, ra_b;
  logic [DW-1:0] rd_a, rd_b;
  logic          busy_a, busy_b, done_a, done_b;

  logic [DW-1:0] rf [NREG];

  rf_dump_reader_if #(.AW(AW), .DW(DW)) if_a ();
  rf_dump_reader_if #(.AW(AW), .DW(DW)) if_b ();

  assign if_a.ready = ready;
  assign if_b.ready = ready;
  assign rd_a = rf[ra_a];
  assign rd_b = rf[ra_b];

  rf_dump_reader #(.NREG(NREG), .AW(AW), .DW(DW), .SKIP_ZERO(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort),
    .ra_o(ra_a), .rd_i(rd_a), .out(if_a), .busy_o(busy_a), .done_o(done_a)
  );

  rf_dump_reader #(.NREG(NREG), .AW(AW), .DW(DW), .SKIP_ZERO(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort),
    .ra_o(ra_b), .rd_i(rd_b), .out(if_b), .busy_o(busy_b), .done_o(done_b)
  );

  // View of the instance currently under test.
  int            sel = 0;
  logic          v_valid, v_last, v_busy, v_done;
  logic [AW-1:0] v_idx, v_ra;
  logic [DW-1:0] v_data;
  always_comb begin
    if (sel == 0) begin
      v_valid = if_a.valid; v_last = if_a.last; v_idx = if_a.idx;
      v_data  = if_a.data;  v_ra   = ra_a;      v_busy = busy_a; v_done = done_a;
    end else begin
      v_valid = if_b.valid; v_last = if_b.last; v_idx = if_b.idx;
      v_data  = if_b.data;  v_ra   = ra_b;      v_busy = busy_b; v_done = done_b;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) start_a = v;
    else        start_b = v;
  endtask

  // One row per cycle: outputs checked at the falling edge, then inputs
  // for that cycle are applied.
  typedef struct {
    logic          start;
    logic          abrt;
    logic          rdy;
    logic          e_valid;
    logic [AW-1:0] e_idx;
    logic [DW-1:0] e_data;
    logic          e_busy;
    logic          e_done;
    logic [AW-1:0] e_ra;
    logic          chk_ra;
  } vec_t;

  vec_t vecs [11];

  // Runs a full dump on instance s and scores every accepted beat against
  // the bench's register-file contents. Optional stall on one index and an
  // optional start pulse while busy.
  task automatic run_dump(input int s, input int first, input int stall_idx,
                          input int stall_len, input int busy_start_idx,
                          input string tag);
    int            exp_idx    = first;
    int            nbeats     = NREG - first;
    int            beats      = 0;
    int            done_cnt   = 0;
    int            done_cyc   = -1;
    int            stall_left = 0;
    bit            stalled    = 1'b0;
    bit            bs_done    = 1'b0;
    sel   = s;
    ready = 1'b1;
    @(posedge clk); #1;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    for (int cyc = 0; cyc < 2 * NREG + 40; cyc++) begin
      @(negedge clk);
      set_start(s, 1'b0);
      if (v_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (stalled && stall_left > 0) begin
        check({tag, "_stall_valid"}, 64'(v_valid), 64'(1));
        check({tag, "_stall_idx"},   64'(v_idx),   64'(stall_idx));
        check({tag, "_stall_data"},  64'(v_data),  64'(rf[stall_idx]));
        check({tag, "_stall_ra"},    64'(v_ra),    64'(stall_idx));
        stall_left--;
        ready = (stall_left == 0);
      end else if (!stalled && v_valid && int'(v_idx) == stall_idx) begin
        stalled    = 1'b1;
        stall_left = stall_len;
        ready      = 1'b0;
      end
      if (v_valid && ready) begin
        if (beats == 0) check({tag, "_first_latency"}, 64'(cyc), 64'(1));
        check({tag, "_idx"},  64'(v_idx),  64'(exp_idx));
        check({tag, "_data"}, 64'(v_data), 64'(rf[exp_idx]));
        check({tag, "_last"}, 64'(v_last), 64'(exp_idx == NREG - 1));
        beats++;
        exp_idx++;
      end
      if (!bs_done && v_valid && int'(v_idx) == busy_start_idx) begin
        set_start(s, 1'b1);
        bs_done = 1'b1;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    set_start(s, 1'b0);
    check({tag, "_beats"},    64'(beats),    64'(nbeats));
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
    check({tag, "_done_cyc"}, 64'(done_cyc), 64'(2 * nbeats + stall_len));
    check({tag, "_idle"},     64'(v_busy),   64'(0));
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) rf[i] = DW'(i) * 32'h1111_1111;

    //                start abrt rdy  valid idx   data          busy done ra    chk_ra
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd1, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h11111111, 1'b1, 1'b0, 5'd1, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 1'b0};

    // Reset state.
    #12;
    check("rst_valid", 64'(if_a.valid), 64'(0));
    check("rst_data",  64'(if_a.data),  64'(0));
    check("rst_idx",   64'(if_a.idx),   64'(0));
    check("rst_last",  64'(if_a.last),  64'(0));
    check("rst_ra",    64'(ra_a),       64'(0));
    check("rst_busy",  64'(busy_a),     64'(0));
    check("rst_done",  64'(done_a),     64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Per-cycle vector table on instance A.
    sel = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 64'(v_valid), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d_busy", i),  64'(v_busy),  64'(vecs[i].e_busy));
      check($sformatf("vec%0d_done", i),  64'(v_done),  64'(vecs[i].e_done));
      check($sformatf("vec%0d_last", i),  64'(v_last),  64'(0));
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_idx", i),  64'(v_idx),  64'(vecs[i].e_idx));
        check($sformatf("vec%0d_data", i), 64'(v_data), 64'(vecs[i].e_data));
      end
      if (vecs[i].chk_ra) check($sformatf("vec%0d_ra", i), 64'(v_ra), 64'(vecs[i].e_ra));
      start_a = vecs[i].start;
      abort   = vecs[i].abrt;
      ready   = vecs[i].rdy;
    end
    @(negedge clk);
    start_a = 1'b0; abort = 1'b0; ready = 1'b0;

    // Full dump, consumer always ready.
    run_dump(0, 0, -1, 0, -1, "full");
    // Register 0 skipped.
    run_dump(1, 1, -1, 0, -1, "skip0");
    // Five cycles of back-pressure on beat 7.
    run_dump(0, 0, 7, 5, -1, "bp");

    // Abort during SEND of index 12.
    begin
      bit found = 1'b0;
      int dones = 0;
      sel = 0; ready = 1'b1;
      @(posedge clk); #1; start_a = 1'b1;
      @(posedge clk); #1; start_a = 1'b0;
      for (int c = 0; c < 2 * NREG + 10 && !found; c++) begin
        @(negedge clk);
        if (v_done) dones++;
        if (v_valid && v_idx == 5'd12) begin
          found = 1'b1;
          abort = 1'b1;
        end
      end
      check("abort_reached_idx12", 64'(found), 64'(1));
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy",  64'(v_busy),  64'(0));
      check("abort_valid", 64'(v_valid), 64'(0));
      check("abort_last",  64'(v_last),  64'(0));
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (v_done) dones++;
      end
      check("abort_no_done", 64'(dones), 64'(0));
    end

    // Restart after abort begins at 0; a start pulse at index 5 is ignored.
    run_dump(0, 0, -1, 0, 5, "restart");

    // Asynchronous reset mid-dump at index 20.
    begin
      bit found = 1'b0;
      sel = 0; ready = 1'b1;
      @(posedge clk); #1; start_a = 1'b1;
      @(posedge clk); #1; start_a = 1'b0;
      for (int c = 0; c < 2 * NREG + 10 && !found; c++) begin
        @(negedge clk);
        if (v_valid && v_idx == 5'd20) found = 1'b1;
      end
      check("arst_reached_idx20", 64'(found), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(if_a.valid), 64'(0));
      check("arst_data",  64'(if_a.data),  64'(0));
      check("arst_idx",   64'(if_a.idx),   64'(0));
      check("arst_last",  64'(if_a.last),  64'(0));
      check("arst_ra",    64'(ra_a),       64'(0));
      check("arst_busy",  64'(busy_a),     64'(0));
      check("arst_done",  64'(done_a),     64'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("arst_post_busy",  64'(busy_a),     64'(0));
      check("arst_post_valid", 64'(if_a.valid), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
